// File: rtl/enemy_pkg.sv
// Shared types and control-word layout for the enemy spawner and its LFSR.
package enemy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam int CTRL_W    = 16;
  localparam int START_LSB = 0;
  localparam int START_W   = 10;
  localparam int FLIP_BIT  = 10;
  localparam int SPEED_LSB = 11;

  // Feedback taps: bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int s);
    return (x << s) | (x >> (16 - s));
  endfunction

  function automatic logic [CTRL_W-1:0] make_word(input logic [15:0] r,
                                                  input logic [1:0]  speed);
    logic [CTRL_W-1:0] w;
    w = '0;
    w[START_LSB +: START_W] = r[START_W-1:0];
    w[FLIP_BIT]             = r[15];
    w[SPEED_LSB +: 2]       = speed;
    return w;
  endfunction

endpackage

// File: rtl/enemy_spawner_lfsr16.sv
// 16-bit Fibonacci LFSR; next is the look-ahead value loaded when en is high.
module lfsr16
  import enemy_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        frame_clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state,
  output logic [15:0] next
);

  // An all-zero register would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  assign next = {state[14:0], ^(state & LFSR_TAPS)};

  always_ff @(posedge frame_clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    if (rst)     state <= SEED_EFF;
    else if (en) state <= next;
  end

endmodule

// File: rtl/enemy_spawner.sv
// Enemy spawner: game FSM, staggered slot activation, difficulty ramp and
// per-slot pseudo-random control words for the enemy sprite instances.
module enemy_spawner
  import enemy_pkg::*;
#(
  parameter int          N_ENEMIES      = 4,
  parameter int          SPAWN_INTERVAL = 60,
  parameter int          LEVEL_FRAMES   = 600,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                          frame_clk,
  input  logic                          rst,
  input  logic                          start_game,
  input  logic                          pause,
  input  logic                          game_over,
  output logic [N_ENEMIES-1:0]          enemy_en,
  output logic [CTRL_W*N_ENEMIES-1:0]   control,
  output logic                          enemy_rst,
  output logic [1:0]                    level,
  output logic [1:0]                    state
);

  localparam int SPW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam int LVW = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;
  localparam logic [SPW-1:0] SPAWN_LAST = SPW'(SPAWN_INTERVAL - 1);
  localparam logic [LVW-1:0] LEVEL_LAST = LVW'(LEVEL_FRAMES - 1);

  state_t                cur_state, state_d;
  logic [N_ENEMIES-1:0]  active_mask, mask_d;
  logic [SPW-1:0]        spawn_cnt, spawn_d;
  logic [LVW-1:0]        level_cnt, lcnt_d;
  logic [1:0]            level_d;
  logic [CTRL_W*N_ENEMIES-1:0] ctrl_d;
  logic                  advance, restart;
  logic [15:0]           lfsr_state, lfsr_next;

  assign state = cur_state;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    state_d = cur_state;
    unique case (cur_state)
      IDLE:    if (start_game) state_d = RUN;
      RUN:     if (game_over) state_d = OVER;
               else if (pause) state_d = PAUSED;
      PAUSED:  if (game_over) state_d = OVER;
               else if (!pause) state_d = RUN;
      OVER:    if (start_game) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign advance = (cur_state == RUN) && (state_d == RUN);
  assign restart = ((cur_state == IDLE) || (cur_state == OVER)) && (state_d == RUN);

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .frame_clk (frame_clk),
    .rst       (rst),
    .en        (advance),
    .state     (lfsr_state),
    .next      (lfsr_next)
  );

  always_comb begin
    mask_d  = active_mask;
    spawn_d = spawn_cnt;
    lcnt_d  = level_cnt;
    level_d = level;
    ctrl_d  = control;
    if (restart) begin
      mask_d  = '0;
      spawn_d = '0;
      lcnt_d  = '0;
      level_d = 2'd0;
    end else if (advance) begin
      if (spawn_cnt == SPAWN_LAST) begin
        spawn_d = '0;
        // Sets the lowest clear bit; an all-ones mask wraps back to itself.
        mask_d  = active_mask | (active_mask + N_ENEMIES'(1));
      end else begin
        spawn_d = spawn_cnt + SPW'(1);
      end
      if (level_cnt == LEVEL_LAST) begin
        lcnt_d  = '0;
        level_d = (level == 2'd3) ? level : level + 2'd1;
      end else begin
        lcnt_d = level_cnt + LVW'(1);
      end
      for (int k = 0; k < N_ENEMIES; k++)
        ctrl_d[CTRL_W*k +: CTRL_W] = make_word(rotl16(lfsr_next, (5 * k) % 16), level_d);
    end
  end

  always_ff @(posedge frame_clk or posedge rst) begin
    if (rst) begin
      cur_state   <= IDLE;
      active_mask <= '0;
      spawn_cnt   <= '0;
      level_cnt   <= '0;
      level       <= 2'd0;
      control     <= '0;
      enemy_en    <= '0;
      enemy_rst   <= 1'b0;
    end else begin
      cur_state   <= state_d;
      active_mask <= mask_d;
      spawn_cnt   <= spawn_d;
      level_cnt   <= lcnt_d;
      level       <= level_d;
      control     <= ctrl_d;
      enemy_en    <= (state_d == RUN) ? mask_d : '0;
      enemy_rst   <= restart;
    end
  end

endmodule

// File: tb/tb_enemy_spawner.sv
// Directed self-checking bench for enemy_spawner with short interval settings.
module tb_enemy_spawner;

  localparam int N  = 4;
  localparam int SI = 4;
  localparam int LF = 8;

  logic           frame_clk = 1'b0;
  logic           rst, start_game, pause, game_over;
  logic [N-1:0]   enemy_en;
  logic [16*N-1:0] control;
  logic           enemy_rst;
  logic [1:0]     level, state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0]     m_lfsr;
  int              m_adv;
  logic [16*N-1:0] m_ctrl;

  enemy_spawner #(
    .N_ENEMIES(N), .SPAWN_INTERVAL(SI), .LEVEL_FRAMES(LF), .LFSR_SEED(16'hACE1)
  ) dut (
    .frame_clk  (frame_clk),
    .rst        (rst),
    .start_game (start_game),
    .pause      (pause),
    .game_over  (game_over),
    .enemy_en   (enemy_en),
    .control    (control),
    .enemy_rst  (enemy_rst),
    .level      (level),
    .state      (state)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] m_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic logic [15:0] m_rotl(input logic [15:0] x, input int s);
    logic [31:0] d;
    d = {x, x};
    return d[31-s -: 16];
  endfunction

  function automatic logic [1:0] lvl_of(input int adv);
    int l;
    l = adv / LF;
    if (l > 3) l = 3;
    return 2'(l);
  endfunction

  function automatic logic [N-1:0] mask_of(input int adv);
    int s;
    s = adv / SI;
    if (s > N) s = N;
    return N'((1 << s) - 1);
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic model_adv();
    logic [15:0] r;
    m_lfsr = m_step(m_lfsr);
    m_adv++;
    for (int k = 0; k < N; k++) begin
      r = m_rotl(m_lfsr, (5 * k) % 16);
      m_ctrl[16*k +: 16] = {3'b000, lvl_of(m_adv), r[15], r[9:0]};
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    m_ctrl = '0;
    m_adv  = 0;
  endtask

  task automatic start_run();
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    m_adv = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_game = 1'b1; pause = 1'b1; game_over = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (state !== 2'd0 || enemy_en !== '0 || control !== '0 || level !== 2'd0 || enemy_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: state=%0d en=%b ctrl=%h level=%0d erst=%b, need all zero",
               state, enemy_en, control, level, enemy_rst);
    end
    rst = 1'b0; start_game = 1'b0;
    m_lfsr = 16'hACE1; m_ctrl = '0; m_adv = 0;
  endtask

  task automatic test_idle_ignore();
    pause = 1'b1; game_over = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (state !== 2'd0 || enemy_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ignore: state=%0d erst=%b, need 0/0", state, enemy_rst);
    end
    pause = 1'b0; game_over = 1'b0;
  endtask

  task automatic test_spawn_level();
    start_run();
    n_cmp++;
    if (state !== 2'd1 || enemy_rst !== 1'b1 || enemy_en !== 4'b0000) begin
      n_bad++;
      $display("FAIL start_edge: state=%0d erst=%b en=%b, need 1/1/0000", state, enemy_rst, enemy_en);
    end
    for (int e = 1; e <= 33; e++) begin
      model_adv();
      tick();
      if (e == 1) begin
        n_cmp++;
        if (control[9:0] !== 10'h1C3 || control[10] !== 1'b0 || control[25:16] !== 10'h06B ||
            control[26] !== 1'b0 || control[12:11] !== 2'b00) begin
          n_bad++;
          $display("FAIL first_words: slot0=%h slot1=%h, need start 1c3/06b flip 0 speed 0",
                   control[15:0], control[31:16]);
        end
      end
      n_cmp++;
      if (enemy_rst !== 1'b0 || enemy_en !== mask_of(e) || level !== lvl_of(e)) begin
        n_bad++;
        $display("FAIL run_edge_%0d: erst=%b en=%b level=%0d, need 0/%b/%0d",
                 e, enemy_rst, enemy_en, level, mask_of(e), lvl_of(e));
      end
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (control[16*k+11 +: 2] !== lvl_of(e)) begin
          n_bad++;
          $display("FAIL speed_e%0d_s%0d: got %0d need %0d", e, k, control[16*k+11 +: 2], lvl_of(e));
        end
      end
      n_cmp++;
      if (control !== m_ctrl) begin
        n_bad++;
        $display("FAIL ctrl_edge_%0d: got %h need %h", e, control, m_ctrl);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    start_run();
    for (int e = 1; e <= 9; e++) begin
      model_adv();
      tick();
    end
    n_cmp++;
    if (enemy_en !== 4'b0011) begin
      n_bad++;
      $display("FAIL pre_pause_mask: got %b need 0011", enemy_en);
    end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (state !== 2'd2 || enemy_en !== 4'b0000 || control !== m_ctrl || level !== lvl_of(m_adv)) begin
        n_bad++;
        $display("FAIL paused_%0d: state=%0d en=%b ctrl=%h level=%0d, need 2/0000/%h/%0d",
                 i, state, enemy_en, control, level, m_ctrl, lvl_of(m_adv));
      end
    end
    pause = 1'b0;
    tick();
    n_cmp++;
    if (state !== 2'd1 || enemy_en !== 4'b0011 || control !== m_ctrl) begin
      n_bad++;
      $display("FAIL resume: state=%0d en=%b ctrl=%h, need 1/0011/%h", state, enemy_en, control, m_ctrl);
    end
    for (int i = 1; i <= 3; i++) begin
      model_adv();
      tick();
      n_cmp++;
      if (enemy_en !== ((i < 3) ? 4'b0011 : 4'b0111) || control !== m_ctrl) begin
        n_bad++;
        $display("FAIL post_resume_%0d: en=%b ctrl=%h, need %b/%h",
                 i, enemy_en, control, (i < 3) ? 4'b0011 : 4'b0111, m_ctrl);
      end
    end
  endtask

  task automatic test_over();
    game_over = 1'b1; pause = 1'b1;
    tick();
    n_cmp++;
    if (state !== 2'd3 || enemy_en !== 4'b0000 || control !== m_ctrl || level !== 2'd1) begin
      n_bad++;
      $display("FAIL enter_over: state=%0d en=%b ctrl=%h level=%0d, need 3/0000/%h/1",
               state, enemy_en, control, level, m_ctrl);
    end
    game_over = 1'b0; pause = 1'b0;
    tick();
    n_cmp++;
    if (state !== 2'd3) begin
      n_bad++;
      $display("FAIL hold_over: state=%0d need 3", state);
    end
    start_run();
    n_cmp++;
    if (state !== 2'd1 || enemy_rst !== 1'b1 || level !== 2'd0 || enemy_en !== 4'b0000) begin
      n_bad++;
      $display("FAIL restart: state=%0d erst=%b level=%0d en=%b, need 1/1/0/0000",
               state, enemy_rst, level, enemy_en);
    end
    for (int e = 1; e <= 4; e++) begin
      model_adv();
      tick();
      n_cmp++;
      if (enemy_rst !== 1'b0 || control !== m_ctrl || level !== 2'd0 || enemy_en !== mask_of(e)) begin
        n_bad++;
        $display("FAIL after_restart_%0d: erst=%b ctrl=%h level=%0d en=%b, need 0/%h/0/%b",
                 e, enemy_rst, control, level, enemy_en, m_ctrl, mask_of(e));
      end
    end
  endtask

  task automatic test_mid_reset();
    @(posedge frame_clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (state !== 2'd0 || enemy_en !== '0 || control !== '0 || level !== 2'd0 || enemy_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: state=%0d en=%b ctrl=%h level=%0d erst=%b, need all zero",
               state, enemy_en, control, level, enemy_rst);
    end
    tick();
    rst = 1'b0;
    start_run();
    tick();
    n_cmp++;
    if (control[15:0] !== 16'h01C3) begin
      n_bad++;
      $display("FAIL reseed_after_rst: slot0=%h need 01c3", control[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_spawn_level();
    test_pause();
    test_over();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
